trace_serializer: RTL and testbench

//  Replay-side counterpart of the trace capture path. Fetches TRB_WIDTH-bit

---
 rtl/trace_serializer.sv | 101 ++++++++++
 tb/tb_trace_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/trace_serializer.sv
// rtl/trace_serializer.sv - replays trace memory words as n-bit slices over a valid/ready stream
// Two word slots (active + prefetch) keep back-to-back words gapless.
module trace_serializer #(
  parameter int TRB_WIDTH       = 32,
  parameter int TRB_MAX_TRACES  = 8,
  parameter int TRB_NTRACE_BITS = 3
) (
  input  logic                       CLK_I,
  input  logic                       RST_NI,
  input  logic [TRB_NTRACE_BITS-1:0] EXP_TRACES_I,
  input  logic [TRB_WIDTH-1:0]       DATA_I,
  input  logic                       LOAD_PERM_I,
  output logic                       LOAD_O,
  output logic                       TRACE_VALID_O,
  input  logic                       TRACE_READY_I,
  output logic [TRB_MAX_TRACES-1:0]  TRACE_O
);

  localparam int PW = $clog2(TRB_WIDTH);
  localparam int MW = $clog2(TRB_MAX_TRACES);
  // Wide enough that pos + n never wraps before the end-of-word compare.
  localparam int CW = PW + 2;

  logic [TRB_WIDTH-1:0]      wreg, wreg_n, breg, breg_n, shifted;
  logic                      wvalid, wvalid_n, bvalid, bvalid_n, run;
  logic [PW-1:0]             pos, pos_n;
  logic [CW-1:0]             n_beat;
  logic [TRB_MAX_TRACES-1:0] trace_q, slice_n;
  logic                      fire, last, slot_free;

  always_comb begin
    n_beat = CW'(TRB_MAX_TRACES);
    if (int'(EXP_TRACES_I) < MW) n_beat = CW'(1) << EXP_TRACES_I;
  end

  assign fire      = wvalid & TRACE_READY_I;
  assign last      = fire & ((CW'(pos) + n_beat) >= CW'(TRB_WIDTH));
  assign slot_free = ~wvalid | last;
  assign LOAD_O    = run & LOAD_PERM_I & ~bvalid;

  always_comb begin
    wreg_n   = wreg;
    breg_n   = breg;
    wvalid_n = wvalid;
    bvalid_n = bvalid;
    pos_n    = pos;
    if (last) begin
      pos_n    = '0;
      wvalid_n = 1'b0;
    end else if (fire) begin
      pos_n = PW'(CW'(pos) + n_beat);
    end
    if (slot_free && bvalid) begin
      wreg_n   = breg;
      wvalid_n = 1'b1;
      bvalid_n = 1'b0;
    end
    if (LOAD_O) begin
      if (slot_free) begin
        wreg_n   = DATA_I;
        wvalid_n = 1'b1;
      end else begin
        breg_n   = DATA_I;
        bvalid_n = 1'b1;
      end
    end
  end

  // Slice for the next cycle; bits past the word end shift in as zero.
  always_comb begin
    shifted = wreg_n >> pos_n;
    slice_n = '0;
    for (int i = 0; i < TRB_MAX_TRACES; i++) begin
      slice_n[i] = shifted[i] & (CW'(i) < n_beat);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      run     <= 1'b0;
      wreg    <= '0;
      breg    <= '0;
      wvalid  <= 1'b0;
      bvalid  <= 1'b0;
      pos     <= '0;
      trace_q <= '0;
    end else begin
      run    <= 1'b1;
      wreg   <= wreg_n;
      breg   <= breg_n;
      wvalid <= wvalid_n;
      bvalid <= bvalid_n;
      pos    <= pos_n;
      if (wvalid_n) trace_q <= slice_n;
    end
  end

  assign TRACE_VALID_O = wvalid;
  assign TRACE_O       = trace_q;

endmodule

// File: tb/tb_trace_serializer.sv
// tb/tb_trace_serializer.sv - randomized and directed bench for trace_serializer
// Reference model: a queue of expected slices plus a count of words held.
module tb_trace_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  exp_tr;
  logic [31:0] data;
  logic        perm, ready;
  logic        load_o, valid_o;
  logic [7:0]  trace_o;

  int          n_pass = 0;
  int          n_total = 0;
  int          held = 0;
  int          n_cur = 8;
  bit          run_m = 0;
  bit          last_load = 0;
  logic [7:0]  last_trace = '0;
  logic [7:0]  sl_q[$];
  bit          end_q[$];

  always #5 clk = ~clk;

  trace_serializer #(.TRB_WIDTH(32), .TRB_MAX_TRACES(8), .TRB_NTRACE_BITS(3)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .EXP_TRACES_I(exp_tr), .DATA_I(data),
    .LOAD_PERM_I(perm), .LOAD_O(load_o), .TRACE_VALID_O(valid_o),
    .TRACE_READY_I(ready), .TRACE_O(trace_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic set_exp(input int e);
    exp_tr = 3'(e);
    n_cur  = (e >= 3) ? 8 : (1 << e);
  endtask

  task automatic push_word(input logic [31:0] w);
    int beats;
    beats = 32 / n_cur;
    for (int k = 0; k < beats; k++) begin
      sl_q.push_back(8'((w >> (k * n_cur)) & ((32'd1 << n_cur) - 1)));
      end_q.push_back(k == beats - 1);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    bit load_m, fire_m;
    @(negedge clk);
    load_m = run_m && perm && (held < 2);
    fire_m = (held > 0) && ready;
    chk("load_o", 32'(load_o), 32'(load_m));
    chk("valid", 32'(valid_o), 32'(held > 0));
    if (sl_q.size() > 0) begin
      chk("trace", 32'(trace_o), 32'(sl_q[0]));
      last_trace = sl_q[0];
    end else begin
      chk("trace_hold", 32'(trace_o), 32'(last_trace));
    end
    if (fire_m && sl_q.size() > 0) begin
      if (end_q[0]) held--;
      void'(sl_q.pop_front());
      void'(end_q.pop_front());
    end
    if (load_m) begin
      push_word(data);
      held++;
    end
    last_load = load_m;
    @(posedge clk);
    if (rst_n) run_m = 1;
    #1;
  endtask

  task automatic drain();
    perm  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 200 && held > 0; i++) tick();
    tick();
  endtask

  task automatic reset_model();
    sl_q.delete();
    end_q.delete();
    held       = 0;
    run_m      = 0;
    last_trace = '0;
  endtask

  initial begin
    logic [31:0] words [2];
    int idx;
    rst_n = 1'b1; perm = 1'b0; ready = 1'b1; data = '0; set_exp(3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_trace", 32'(trace_o), 32'd0);
    chk("rst_load", 32'(load_o), 32'd0);
    @(posedge clk); #1;
    perm = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // One word, 8-bit slices
    data = 32'h89ABCDEF; perm = 1'b1;
    tick();
    perm = 1'b0;
    drain();

    // Two words back to back
    words[0] = 32'h03020100; words[1] = 32'h07060504; idx = 0;
    for (int c = 0; c < 12; c++) begin
      perm = (idx < 2);
      data = words[idx % 2];
      tick();
      if (last_load) idx++;
    end
    drain();

    // 1-bit slices
    set_exp(0);
    data = 32'h80000001; perm = 1'b1;
    tick();
    drain();

    // 4-bit slices with stalls
    set_exp(2);
    for (int c = 0; c < 40; c++) begin
      perm  = 1'b1;
      data  = $urandom;
      ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    drain();

    // Exponent above the maximum clamps to 8
    set_exp(5);
    data = 32'hA5C3_1E7F; perm = 1'b1;
    tick(); tick();
    drain();

    // Reset mid-word with a buffered word
    set_exp(3);
    perm = 1'b1; data = 32'h11223344;
    tick();
    data = 32'h55667788;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_trace", 32'(trace_o), 32'd0);
    reset_model();
    tick(); tick();
    rst_n = 1'b1;
    data = 32'hDEADBEEF;
    tick();
    tick();
    perm = 1'b0;
    drain();

    // Random traffic at every exponent
    for (int e = 0; e < 8; e++) begin
      set_exp(e);
      for (int c = 0; c < 60; c++) begin
        perm  = ($urandom_range(0, 3) != 0);
        ready = ($urandom_range(0, 3) != 0);
        data  = $urandom;
        tick();
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
